// File: rtl/count_window_monitor_if.sv
// rtl/count_window_monitor_if.sv - bus bundle between the counter side and the window monitor
//
// Purpose : groups the sampled counter signals, window/mask configuration and the
//           monitor results into one bundle.
// Signals : count_in, updn_in, preload_in   counter cout / updn / preload copies
//           lo_thr, hi_thr                  inclusive window bounds
//           irq_mask, clr, clr_mask         irq enables and sticky-status clear
//           status, zone, irq, wrap_cnt     monitor results
// Modports: master drives counter/config signals and observes results;
//           slave is the monitor side.

interface count_window_monitor_if #(
    parameter int W      = 8,
    parameter int WCNT_W = 8
);
    logic [W-1:0]      count_in;
    logic              updn_in;
    logic              preload_in;
    logic [W-1:0]      lo_thr;
    logic [W-1:0]      hi_thr;
    logic [3:0]        irq_mask;
    logic              clr;
    logic [3:0]        clr_mask;
    logic [3:0]        status;
    logic [1:0]        zone;
    logic              irq;
    logic [WCNT_W-1:0] wrap_cnt;

    modport master (
        output count_in, updn_in, preload_in, lo_thr, hi_thr,
               irq_mask, clr, clr_mask,
        input  status, zone, irq, wrap_cnt
    );

    modport slave (
        input  count_in, updn_in, preload_in, lo_thr, hi_thr,
               irq_mask, clr, clr_mask,
        output status, zone, irq, wrap_cnt
    );
endinterface

// File: rtl/count_window_monitor.sv
// rtl/count_window_monitor.sv - window/zone and wrap-around monitor for an up/down counter
//
// Purpose : samples the counter output every clock, classifies it against an
//           inclusive [lo_thr, hi_thr] window, flags window entry/exit and
//           up/down wrap-around in sticky status bits, drives a level irq and
//           (optionally) keeps a saturating wrap counter.
// Ports   : i_clk    clock, all state on posedge
//           i_reset  synchronous active-high reset
//           bus      count_window_monitor_if.slave
//                    status = {wrap_dn, wrap_up, exit_win, enter_win}
//                    zone   = 0 INIT, 1 LOW, 2 IN, 3 HIGH
// Config  : COUNT_MON_WRAPCNT_EN defined   -> wrap_cnt register present
//           COUNT_MON_WRAPCNT_EN undefined -> wrap_cnt tied to zero

module count_window_monitor #(
    parameter int W      = 8,
    parameter int WCNT_W = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    count_window_monitor_if.slave  bus
);

    typedef enum logic [1:0] {
        Z_INIT = 2'd0,
        Z_LOW  = 2'd1,
        Z_IN   = 2'd2,
        Z_HIGH = 2'd3
    } zone_t;

    zone_t        r_zone;
    zone_t        w_zone_nxt;
    logic [W-1:0] r_prev_cnt;
    logic         r_prev_valid;
    logic         r_updn_d;
    logic         r_preload_d;
    logic [3:0]   r_status;
    logic [3:0]   w_status_nxt;
    logic [3:0]   w_clr_bits;
    logic         w_enter;
    logic         w_exit;
    logic         w_wrap_up;
    logic         w_wrap_dn;

    // State registers. The counter's updn/preload are delayed one cycle because
    // the count seen this cycle is the result of last cycle's controls.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_zone       <= Z_INIT;
            r_prev_cnt   <= '0;
            r_prev_valid <= 1'b0;
            r_updn_d     <= 1'b1;
            r_preload_d  <= 1'b0;
            r_status     <= 4'h0;
        end else begin
            r_zone       <= w_zone_nxt;
            r_prev_cnt   <= bus.count_in;
            r_prev_valid <= 1'b1;
            r_updn_d     <= bus.updn_in;
            r_preload_d  <= bus.preload_in;
            r_status     <= w_status_nxt;
        end
    end

    // Zone FSM next state and event decode.
    always_comb begin
        w_zone_nxt = Z_IN;
        w_enter    = 1'b0;
        w_exit     = 1'b0;

        // LOW is tested first so an inverted window (lo > hi) never yields IN.
        if (bus.count_in < bus.lo_thr) begin
            w_zone_nxt = Z_LOW;
        end else if (bus.count_in > bus.hi_thr) begin
            w_zone_nxt = Z_HIGH;
        end else begin
            w_zone_nxt = Z_IN;
        end

        case (r_zone)
            Z_INIT: begin
                // First sample after reset only establishes the zone.
                w_enter = 1'b0;
                w_exit  = 1'b0;
            end
            Z_LOW, Z_HIGH: begin
                w_enter = (w_zone_nxt == Z_IN);
                // A direct LOW<->HIGH jump skipped the window: report exit only.
                w_exit  = (w_zone_nxt != Z_IN) && (w_zone_nxt != r_zone);
            end
            Z_IN: begin
                w_exit  = (w_zone_nxt != Z_IN);
            end
            default: begin
                w_enter = 1'b0;
                w_exit  = 1'b0;
            end
        endcase
    end

    // Wrap detection: a count moving against the counting direction means the
    // counter rolled over. A preload breaks that relationship, so it masks it.
    always_comb begin
        w_wrap_up = 1'b0;
        w_wrap_dn = 1'b0;
        if (r_prev_valid && !r_preload_d) begin
            w_wrap_up = r_updn_d  && (bus.count_in < r_prev_cnt);
            w_wrap_dn = !r_updn_d && (bus.count_in > r_prev_cnt);
        end
    end

    // Sticky status: new events are OR-ed in after the clear, so set beats clear.
    always_comb begin
        w_clr_bits   = bus.clr ? bus.clr_mask : 4'h0;
        w_status_nxt = (r_status & ~w_clr_bits) | {w_wrap_dn, w_wrap_up, w_exit, w_enter};
    end

    assign bus.status = r_status;
    assign bus.zone   = r_zone;
    assign bus.irq    = |(r_status & bus.irq_mask);

`ifdef COUNT_MON_WRAPCNT_EN
    localparam logic [WCNT_W-1:0] WCNT_MAX = '1;

    logic [WCNT_W-1:0] r_wrap_cnt;
    logic [WCNT_W-1:0] w_wrap_cnt_nxt;
    logic              w_any_wrap;
    logic              w_wrap_cnt_clr;

    always_comb begin
        w_any_wrap     = w_wrap_up | w_wrap_dn;
        w_wrap_cnt_clr = bus.clr && (bus.clr_mask[3:2] == 2'b11);
        w_wrap_cnt_nxt = r_wrap_cnt;
        if (w_wrap_cnt_clr) begin
            // Clear and increment in the same cycle: this cycle's wrap survives.
            w_wrap_cnt_nxt = w_any_wrap ? WCNT_W'(1) : '0;
        end else if (w_any_wrap && (r_wrap_cnt != WCNT_MAX)) begin
            w_wrap_cnt_nxt = r_wrap_cnt + WCNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wrap_cnt <= '0;
        end else begin
            r_wrap_cnt <= w_wrap_cnt_nxt;
        end
    end

    assign bus.wrap_cnt = r_wrap_cnt;
`else
    assign bus.wrap_cnt = '0;
`endif

endmodule
